// File: rtl/jtag_scan_master.sv
// JTAG host: turns one queued command (TAP reset, IR/DR scan, idle clocks) into
// a TCK/TMS/TDI period sequence and returns the captured TDO bits.
module jtag_scan_master #(
  parameter int MaxLen = 64,
  parameter int ClkDiv = 1,
  parameter int LenW   = $clog2(MaxLen + 1)
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  output logic              jtag_trst_no,
  input  logic              jtag_tdo_i
);

  localparam int KW = $clog2(MaxLen + 7);
  localparam int IW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int DW = $clog2(2 * ClkDiv + 1);
  localparam logic [DW-1:0] DivRise = DW'(ClkDiv - 1);
  localparam logic [DW-1:0] DivSamp = DW'(ClkDiv);
  localparam logic [DW-1:0] DivLast = DW'(2 * ClkDiv - 1);
  localparam logic [1:0] OpReset = 2'd0, OpIr = 2'd1, OpDr = 2'd2, OpIdle = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;
  typedef struct packed {logic tms; logic tdi; logic trst_n;} pins_t;

  function automatic logic [KW-1:0] shift_start(input logic [1:0] op);
    return (op == OpIr) ? KW'(4) : KW'(3);
  endfunction

  function automatic logic in_shift(input logic [1:0] op, input logic [LenW-1:0] n,
                                    input logic [KW-1:0] k);
    return ((op == OpIr) || (op == OpDr)) && (k >= shift_start(op)) &&
           (k < shift_start(op) + KW'(n));
  endfunction

  function automatic logic [IW-1:0] shift_idx(input logic [1:0] op, input logic [KW-1:0] k);
    logic [KW-1:0] d;
    d = k - shift_start(op);
    return d[IW-1:0];
  endfunction

  function automatic logic [KW-1:0] total_periods(input logic [1:0] op, input logic [LenW-1:0] n);
    logic [KW-1:0] t;
    case (op)
      OpReset: t = KW'(6);
      OpIr:    t = KW'(n) + KW'(6);
      OpDr:    t = KW'(n) + KW'(5);
      default: t = KW'(n);
    endcase
    return t;
  endfunction

  // Pin values for TCK period k of a command; the shift window sits between
  // the navigation prefix (RTI->Shift) and the Exit1->Update->RTI tail.
  function automatic pins_t period_pins(input logic [1:0] op, input logic [LenW-1:0] n,
                                        input logic [KW-1:0] k, input logic [MaxLen-1:0] data);
    pins_t p;
    logic [KW-1:0] tail;
    p = '0;
    p.trst_n = 1'b1;
    tail = shift_start(op) + KW'(n);
    case (op)
      OpReset: begin
        p.tms    = (k < KW'(5));
        p.trst_n = (k >= KW'(5));
      end
      OpIr, OpDr: begin
        if (in_shift(op, n, k)) begin
          p.tms = (k == tail - KW'(1));
          p.tdi = data[shift_idx(op, k)];
        end else if (k == tail) begin
          p.tms = 1'b1;
        end else if (op == OpIr) begin
          p.tms = (k < KW'(2));
        end else begin
          p.tms = (k == '0);
        end
      end
      default: ;
    endcase
    return p;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [MaxLen-1:0] data_q, data_d;
  logic [KW-1:0]     tot_q, tot_d, per_q, per_d;
  logic [DW-1:0]     div_q, div_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic [MaxLen-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              len_ok;
  pins_t             first_pins, next_pins;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    tot_d      = tot_q;
    per_d      = per_q;
    div_d      = div_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    trst_d     = trst_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    len_ok     = (cmd_len_i != '0) && (cmd_len_i <= LenW'(MaxLen));
    first_pins = period_pins(cmd_op_i, cmd_len_i, '0, cmd_data_i);
    next_pins  = period_pins(op_q, len_q, per_q + KW'(1), data_q);
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          op_d       = cmd_op_i;
          len_d      = cmd_len_i;
          data_d     = cmd_data_i;
          tot_d      = total_periods(cmd_op_i, cmd_len_i);
          per_d      = '0;
          div_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (((cmd_op_i == OpIr) || (cmd_op_i == OpDr)) && !len_ok) begin
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end else if ((cmd_op_i == OpIdle) && (cmd_len_i == '0)) begin
            state_d = StResp;
          end else begin
            state_d = StRun;
            tms_d   = first_pins.tms;
            tdi_d   = first_pins.tdi;
            trst_d  = first_pins.trst_n;
          end
        end
      end
      StRun: begin
        div_d = div_q + DW'(1);
        if (div_q == DivRise) tck_d = 1'b1;
        if ((div_q == DivSamp) && in_shift(op_q, len_q, per_q))
          rsp_data_d[shift_idx(op_q, per_q)] = jtag_tdo_i;
        // Period boundary: TCK falls and the next period's TMS/TDI launch together.
        if (div_q == DivLast) begin
          tck_d = 1'b0;
          div_d = '0;
          if (per_q == tot_q - KW'(1)) begin
            state_d = StResp;
          end else begin
            per_d  = per_q + KW'(1);
            tms_d  = next_pins.tms;
            tdi_d  = next_pins.tdi;
            trst_d = next_pins.trst_n;
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d    = StIdle;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q    <= StIdle;
      op_q       <= OpReset;
      len_q      <= '0;
      data_q     <= '0;
      tot_q      <= '0;
      per_q      <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      trst_q     <= 1'b1;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      tot_q      <= tot_d;
      per_q      <= per_d;
      div_q      <= div_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      trst_q     <= trst_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle) && !reset_i;
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;

endmodule
